// File: rtl/axi_lite_read_arbiter.sv
// Two-requester AXI-Lite read arbiter: round-robin grant, one outstanding read at a time.
// Optional transaction timeout with DEADBEEF error response is enabled by defining ARB_TIMEOUT_EN.
module axi_lite_read_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [1:0]              i_m_arvalid,
    output logic [1:0]              o_m_arready,
    input  logic [2*ADDR_WIDTH-1:0] i_m_araddr,
    output logic [1:0]              o_m_rvalid,
    input  logic [1:0]              i_m_rready,
    output logic [DATA_WIDTH-1:0]   o_m_rdata,
    output logic                    o_s_arvalid,
    input  logic                    i_s_arready,
    output logic [ADDR_WIDTH-1:0]   o_s_araddr,
    input  logic                    i_s_rvalid,
    output logic                    o_s_rready,
    input  logic [DATA_WIDTH-1:0]   i_s_rdata,
    output logic [1:0]              o_grant,
    output logic                    o_timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;
    localparam logic [DATA_WIDTH-1:0] ErrData  = DATA_WIDTH'(32'hDEAD_BEEF);
    localparam logic [15:0]           LastTick = 16'(TIMEOUT_CYCLES - 1);
`else
    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;
`endif

    state_e     state;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic       data_done;

    // Tie goes to whoever did not own the previous transaction.
    always_comb begin
        winner = 2'b00;
        case (i_m_arvalid)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = (last_grant == 2'b01) ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

    assign data_done = i_s_rvalid & (|(o_grant & i_m_rready));

`ifdef ARB_TIMEOUT_EN
    logic [15:0] timer;
    logic        timer_expired;

    assign timer_expired = (timer == LastTick);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
        end else if (state == StIdle) begin
            timer <= '0;
        end else if (state == StAddr || state == StData) begin
            timer <= timer + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            o_grant    <= 2'b00;
            last_grant <= 2'b10;
            o_s_araddr <= '0;
`ifdef ARB_TIMEOUT_EN
            o_timeout  <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (|i_m_arvalid) begin
                        o_grant    <= winner;
                        o_s_araddr <= winner[1] ? i_m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                                : i_m_araddr[ADDR_WIDTH-1:0];
                        state      <= StAddr;
                    end
                end
                StAddr: begin
`ifdef ARB_TIMEOUT_EN
                    if (timer_expired) begin
                        state     <= StErr;
                        o_timeout <= 1'b1;
                    end else
`endif
                    if (i_s_arready) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (data_done) begin
                        state      <= StIdle;
                        last_grant <= o_grant;
                        o_grant    <= 2'b00;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timer_expired) begin
                        state     <= StErr;
                        o_timeout <= 1'b1;
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                StErr: begin
                    if (|(o_grant & i_m_rready)) begin
                        state      <= StIdle;
                        last_grant <= o_grant;
                        o_grant    <= 2'b00;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign o_timeout = 1'b0;
`endif

    // Downstream rready stays high outside DATA so stale responses are swallowed.
    always_comb begin
        o_m_arready = 2'b00;
        o_s_arvalid = 1'b0;
        o_m_rvalid  = 2'b00;
        o_s_rready  = 1'b1;
        o_m_rdata   = '0;
        unique case (state)
            StIdle: o_m_arready = resetn ? winner : 2'b00;
            StAddr: o_s_arvalid = 1'b1;
            StData: begin
                o_m_rvalid = o_grant & {2{i_s_rvalid}};
                o_s_rready = |(o_grant & i_m_rready);
                o_m_rdata  = i_s_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            StErr: begin
                o_m_rvalid = o_grant;
                o_m_rdata  = ErrData;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Self-checking bench for axi_lite_read_arbiter: directed scenarios plus randomized reads
// checked against a round-robin transaction model.
module tb_axi_lite_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    m_arvalid = '0;
    logic [1:0]    m_arready;
    logic [2*AW-1:0] m_araddr = '0;
    logic [1:0]    m_rvalid;
    logic [1:0]    m_rready = '0;
    logic [DW-1:0] m_rdata;
    logic          s_arvalid;
    logic          s_arready = 1'b0;
    logic [AW-1:0] s_araddr;
    logic          s_rvalid = 1'b0;
    logic          s_rready;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    grant;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int last_w   = 1;  // model: index of the requester that owned the last completed read

    axi_lite_read_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_m_arvalid(m_arvalid),
        .o_m_arready(m_arready),
        .i_m_araddr (m_araddr),
        .o_m_rvalid (m_rvalid),
        .i_m_rready (m_rready),
        .o_m_rdata  (m_rdata),
        .o_s_arvalid(s_arvalid),
        .i_s_arready(s_arready),
        .o_s_araddr (s_araddr),
        .i_s_rvalid (s_rvalid),
        .o_s_rready (s_rready),
        .i_s_rdata  (s_rdata),
        .o_grant    (grant),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: sole requester wins; on a tie the one not served last wins.
    function automatic int pick(input logic [1:0] req);
        if (req == 2'b11) return (last_w == 0) ? 1 : 0;
        return req[1] ? 1 : 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full read; starts and ends 1 time unit after a rising edge with the DUT idle.
    task automatic txn(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input int ar_dly, input int r_dly, input int rr_dly,
                       input logic [31:0] data, output logic [1:0] obs_g);
        int w;
        int k;
        logic [1:0] gw;
        logic done;
        w  = pick(req);
        gw = (w == 1) ? 2'b10 : 2'b01;
        m_arvalid = req;
        m_araddr  = {a1, a0};
        #4;
        chk("ar_ready", m_arready, gw);
        cyc();
        m_arvalid[w] = 1'b0;  // a losing requester keeps asking
        s_arready = (ar_dly == 0);
        #4;
        obs_g = grant;
        chk("grant", grant, gw);
        chk("s_araddr", s_araddr, (w == 1) ? a1 : a0);
        chk("s_arvalid", s_arvalid, 1'b1);
        cyc();
        for (int i = 1; i <= ar_dly; i++) begin
            s_arready = (i == ar_dly);
            #4;
            chk("s_arvalid_hold", s_arvalid, 1'b1);
            chk("arready_busy", m_arready, 2'b00);
            cyc();
        end
        s_arready = 1'b0;
        k = 0;
        done = 1'b0;
        while (!done && k < 100) begin
            s_rvalid = (k >= r_dly);
            s_rdata  = s_rvalid ? data : $urandom;
            m_rready[w]     = (k >= rr_dly);
            m_rready[1 - w] = 1'($urandom);
            #4;
            chk("s_arvalid_drop", s_arvalid, 1'b0);
            chk("m_rvalid", m_rvalid, s_rvalid ? gw : 2'b00);
            chk("s_rready", s_rready, m_rready[w]);
            chk("arready_data", m_arready, 2'b00);
            if (s_rvalid) chk("m_rdata", m_rdata, data);
            done = s_rvalid & m_rready[w];
            cyc();
            k++;
        end
        if (!done) chk("data_done", 1'b0, 1'b1);
        s_rvalid = 1'b0;
        m_rready = 2'b00;
        last_w = w;
        chk("grant_clear", grant, 2'b00);
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] req;
        int k;

        // Reset state
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_araddr", s_araddr, 0);
        chk("rst_arvalid", s_arvalid, 1'b0);
        chk("rst_arready", m_arready, 2'b00);
        chk("rst_rvalid", m_rvalid, 2'b00);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_rready", s_rready, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        cyc();

        // Simultaneous requests alternate starting with the CPU
        txn(2'b11, 32'h1000_0000, 32'h2000_0000, 0, 0, 0, 32'hA0, g);
        chk("rr_order0", g, 2'b01);
        txn(2'b11, 32'h1000_0004, 32'h2000_0004, 1, 0, 0, 32'hA1, g);
        chk("rr_order1", g, 2'b10);
        txn(2'b11, 32'h1000_0008, 32'h2000_0008, 0, 1, 0, 32'hA2, g);
        chk("rr_order2", g, 2'b01);
        txn(2'b11, 32'h1000_000C, 32'h2000_000C, 0, 0, 1, 32'hA3, g);
        chk("rr_order3", g, 2'b10);

        // CPU stalls rready for 5 cycles while requester 1 keeps requesting
        txn(2'b11, 32'h3000_0000, 32'h4000_0000, 0, 0, 5, 32'h55, g);
        chk("stall_owner", g, 2'b01);
        txn(2'b10, 32'h0, 32'h4000_0000, 0, 0, 0, 32'h66, g);
        chk("loser_next", g, 2'b10);

        // CPU-only read
        txn(2'b01, 32'h0100_0000, 32'h0, 0, 0, 0, 32'h0000_0013, g);
        chk("cpu_only", g, 2'b01);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            req = 2'($urandom_range(1, 3));
            txn(req, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom, g);
        end
        chk("no_timeout", timeout, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Slave never accepts the address
        m_arvalid = 2'b01;
        m_araddr  = {32'h0, 32'h0BAD_0000};
        cyc();
        m_arvalid = 2'b00;
        k = 0;
        while (s_arvalid && k < 100) begin
            k++;
            cyc();
        end
        chk("to_cycles", k, TO);
        #3;
        chk("err_rvalid", m_rvalid, 2'b01);
        chk("err_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("err_flag", timeout, 1'b1);
        chk("err_arvalid", s_arvalid, 1'b0);
        chk("err_rready", s_rready, 1'b1);
        m_rready = 2'b01;
        cyc();
        m_rready = 2'b00;
        last_w = 0;
        chk("err_exit", grant, 2'b00);
        s_rvalid = 1'b1;
        #3;
        chk("stale_rvalid", m_rvalid, 2'b00);
        chk("stale_rready", s_rready, 1'b1);
        chk("flag_sticky", timeout, 1'b1);
        cyc();
        s_rvalid = 1'b0;
`endif

        // Reset asserted in the middle of the data phase
        m_arvalid = 2'b10;
        m_araddr  = {32'h7000_0000, 32'h0};
        cyc();
        m_arvalid = 2'b00;
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        m_arvalid = 2'b11;
        #2;
        chk("pre_rst_rvalid", m_rvalid, 2'b10);
        resetn = 1'b0;
        #1;
        chk("arst_grant", grant, 2'b00);
        chk("arst_araddr", s_araddr, 0);
        chk("arst_arvalid", s_arvalid, 1'b0);
        chk("arst_arready", m_arready, 2'b00);
        chk("arst_rvalid", m_rvalid, 2'b00);
        chk("arst_timeout", timeout, 1'b0);
        m_arvalid = 2'b00;
        @(negedge clk);
        resetn = 1'b1;
        last_w = 1;
        cyc();
        chk("no_replay_arvalid", s_arvalid, 1'b0);
        chk("no_replay_grant", grant, 2'b00);
        chk("stale_after_rst", m_rvalid, 2'b00);
        s_rvalid = 1'b0;
        txn(2'b11, 32'h0C00_0000, 32'h0D00_0000, 0, 0, 0, 32'h77, g);
        chk("cpu_first_after_rst", g, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
